// File: rtl/or1k_icache_refill_wb.sv
// Instruction-cache line refill engine: fetches one cache line over Wishbone B3
// as a wrapping burst, critical word first, and streams each word into the cache.
module or1k_icache_refill_wb #(
   parameter int OPTION_OPERAND_WIDTH      = 32,
   parameter int OPTION_ICACHE_BLOCK_WIDTH = 5
) (
   input  logic                            clk,
   input  logic                            rst,

   input  logic                            refill_req_i,
   input  logic [OPTION_OPERAND_WIDTH-1:0] refill_adr_i,

   output logic [OPTION_OPERAND_WIDTH-1:0] wradr_o,
   output logic [OPTION_OPERAND_WIDTH-1:0] wrdat_o,
   output logic                            we_o,
   output logic                            err_o,

   output logic [OPTION_OPERAND_WIDTH-1:0] wbm_adr_o,
   input  logic [OPTION_OPERAND_WIDTH-1:0] wbm_dat_i,
   output logic                            wbm_cyc_o,
   output logic                            wbm_stb_o,
   output logic                            wbm_we_o,
   output logic [3:0]                      wbm_sel_o,
   output logic [2:0]                      wbm_cti_o,
   output logic [1:0]                      wbm_bte_o,
   input  logic                            wbm_ack_i,
   input  logic                            wbm_err_i
);

   localparam int AW = OPTION_OPERAND_WIDTH;
   localparam int BW = OPTION_ICACHE_BLOCK_WIDTH;
   localparam int CW = BW - 2;

   localparam logic [CW-1:0] LAST_BEAT = '1;
   localparam logic [AW-1:0] WORD_MASK = {{(AW-2){1'b1}}, 2'b00};
   localparam logic [1:0]    BTE_WRAP  = (BW == 5) ? 2'b10 : 2'b01;

   typedef enum logic [1:0] {
      IDLE,
      BURST,
      DONE
   } state_t;

   state_t        state;
   logic [CW-1:0] beat_cnt;
   logic          req_dropped;
   logic [CW-1:0] next_ofs;

   // Only the word offset inside the line moves; tag/index bits stay put, so the burst wraps.
   assign next_ofs  = wbm_adr_o[BW-1:2] + CW'(1);

   assign wbm_we_o  = 1'b0;
   assign wbm_sel_o = 4'hf;
   assign wbm_bte_o = BTE_WRAP;
   assign wbm_cti_o = (beat_cnt == LAST_BEAT) ? 3'b111 : 3'b010;

   // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         beat_cnt    <= '0;
         req_dropped <= 1'b0;
         wbm_adr_o   <= '0;
         wbm_cyc_o   <= 1'b0;
         wbm_stb_o   <= 1'b0;
         wradr_o     <= '0;
         wrdat_o     <= '0;
         we_o        <= 1'b0;
         err_o       <= 1'b0;
      end else begin
         we_o  <= 1'b0;
         err_o <= 1'b0;

         unique case (state)
            IDLE: begin
               if (refill_req_i) begin
                  wbm_adr_o   <= refill_adr_i & WORD_MASK;
                  beat_cnt    <= '0;
                  req_dropped <= 1'b0;
                  wbm_cyc_o   <= 1'b1;
                  wbm_stb_o   <= 1'b1;
                  state       <= BURST;
               end
            end

            BURST: begin
               // A withdrawn request still lets the burst finish, but the cache no longer wants the words.
               if (!refill_req_i)
                  req_dropped <= 1'b1;

               if (wbm_err_i) begin
                  wbm_cyc_o <= 1'b0;
                  wbm_stb_o <= 1'b0;
                  err_o     <= 1'b1;
                  state     <= DONE;
               end else if (wbm_ack_i) begin
                  wradr_o   <= wbm_adr_o;
                  wrdat_o   <= wbm_dat_i;
                  we_o      <= refill_req_i & ~req_dropped;
                  beat_cnt  <= beat_cnt + CW'(1);
                  wbm_adr_o <= {wbm_adr_o[AW-1:BW], next_ofs, wbm_adr_o[1:0]};
                  if (beat_cnt == LAST_BEAT) begin
                     wbm_cyc_o <= 1'b0;
                     wbm_stb_o <= 1'b0;
                     state     <= DONE;
                  end
               end
            end

            DONE: begin
               if (!refill_req_i)
                  state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_or1k_icache_refill_wb.sv
// Scoreboard bench for the refill engine: one 8-beat-line and one 4-beat-line instance
// driven by a randomised Wishbone slave, checked against line-wrap arithmetic.
module tb_or1k_icache_refill_wb;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        req   [2];
   logic [31:0] radr  [2];
   logic [31:0] wradr [2];
   logic [31:0] wrdat [2];
   logic        we    [2];
   logic        err   [2];
   logic [31:0] adr   [2];
   logic [31:0] dat   [2];
   logic        cyc   [2];
   logic        stb   [2];
   logic        wwe   [2];
   logic [3:0]  sel   [2];
   logic [2:0]  cti   [2];
   logic [1:0]  bte   [2];
   logic        ack   [2];
   logic        berr  [2];

   or1k_icache_refill_wb #(.OPTION_OPERAND_WIDTH(32), .OPTION_ICACHE_BLOCK_WIDTH(5)) u_dut8 (
      .clk(clk), .rst(rst),
      .refill_req_i(req[0]), .refill_adr_i(radr[0]),
      .wradr_o(wradr[0]), .wrdat_o(wrdat[0]), .we_o(we[0]), .err_o(err[0]),
      .wbm_adr_o(adr[0]), .wbm_dat_i(dat[0]), .wbm_cyc_o(cyc[0]), .wbm_stb_o(stb[0]),
      .wbm_we_o(wwe[0]), .wbm_sel_o(sel[0]), .wbm_cti_o(cti[0]), .wbm_bte_o(bte[0]),
      .wbm_ack_i(ack[0]), .wbm_err_i(berr[0])
   );

   or1k_icache_refill_wb #(.OPTION_OPERAND_WIDTH(32), .OPTION_ICACHE_BLOCK_WIDTH(4)) u_dut4 (
      .clk(clk), .rst(rst),
      .refill_req_i(req[1]), .refill_adr_i(radr[1]),
      .wradr_o(wradr[1]), .wrdat_o(wrdat[1]), .we_o(we[1]), .err_o(err[1]),
      .wbm_adr_o(adr[1]), .wbm_dat_i(dat[1]), .wbm_cyc_o(cyc[1]), .wbm_stb_o(stb[1]),
      .wbm_we_o(wwe[1]), .wbm_sel_o(sel[1]), .wbm_cti_o(cti[1]), .wbm_bte_o(bte[1]),
      .wbm_ack_i(ack[1]), .wbm_err_i(berr[1])
   );

   typedef struct {
      logic [31:0] adr;
      bit          last;
   } beat_t;

   typedef struct {
      logic [31:0] adr;
      logic [31:0] dat;
   } wr_t;

   beat_t       bus_q [2][$];
   wr_t         wr_q  [2][$];
   int          exp_err  [2];
   int          max_wait [2];
   int          err_beat [2];
   int          n_ack    [2] = '{0, 0};
   logic [31:0] salt;
   int          n_checks = 0;
   int          n_fail   = 0;

   function automatic logic [31:0] mem_f(logic [31:0] a);
      return a * 32'h9E37_79B1 + salt;
   endfunction

   function automatic int line_bytes(int d);
      return (d == 0) ? 32 : 16;
   endfunction

   task automatic check(int d, bit ok, string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL dut%0d %s: got %h want %h", d, name, act, exp);
      end
   endtask

   // Wishbone slave: random wait states, data is a hash of the address, optional error beat.
   initial begin
      int wait_left [2];
      int beat      [2];
      for (int i = 0; i < 2; i++) begin
         ack[i] = 1'b0; berr[i] = 1'b0; dat[i] = '0;
         wait_left[i] = 0; beat[i] = 0;
      end
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < 2; i++) begin
            ack[i]  = 1'b0;
            berr[i] = 1'b0;
            if (!rst && cyc[i] && stb[i]) begin
               if (wait_left[i] > 0) begin
                  wait_left[i]--;
               end else begin
                  ack[i] = 1'b1;
                  dat[i] = mem_f(adr[i]);
                  beat[i]++;
                  if (beat[i] == err_beat[i]) berr[i] = 1'b1;
                  wait_left[i] = int'($urandom_range(max_wait[i], 0));
               end
            end else begin
               beat[i]      = 0;
               wait_left[i] = int'($urandom_range(max_wait[i], 0));
            end
         end
      end
   end

   always @(posedge clk)
      for (int i = 0; i < 2; i++)
         if (!rst && ack[i] && cyc[i] && stb[i]) n_ack[i] <= n_ack[i] + 1;

   // Monitor: pops expected bus beats, cache writes and error pulses as the DUTs present them.
   initial begin
      bit    prev_ack [2];
      bit    prev_err [2];
      bit    prev_end [2];
      bit    pres, ends;
      beat_t b;
      wr_t   w;
      logic [2:0] exp_cti;
      logic [1:0] exp_bte;
      for (int i = 0; i < 2; i++) begin
         prev_ack[i] = 0; prev_err[i] = 0; prev_end[i] = 0;
      end
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (rst) begin
               prev_ack[i] = 0; prev_err[i] = 0; prev_end[i] = 0;
               continue;
            end
            if (prev_end[i])
               check(i, !cyc[i] && !stb[i], "cyc_drop_after_end", {cyc[i], stb[i]}, 0);
            pres = ack[i] && cyc[i] && stb[i];
            ends = 0;
            if (pres) begin
               if (bus_q[i].size() == 0) begin
                  check(i, 0, "unexpected_bus_beat", adr[i], 0);
               end else begin
                  b       = bus_q[i].pop_front();
                  exp_cti = b.last ? 3'b111 : 3'b010;
                  exp_bte = (i == 0) ? 2'b10 : 2'b01;
                  ends    = b.last || berr[i];
                  check(i, adr[i] == b.adr, "bus_adr", adr[i], b.adr);
                  check(i, cti[i] == exp_cti && bte[i] == exp_bte && !wwe[i] && sel[i] == 4'hf,
                        "bus_ctl", {cti[i], bte[i], wwe[i], sel[i]}, {exp_cti, exp_bte, 1'b0, 4'hf});
               end
            end
            if (we[i]) begin
               if (wr_q[i].size() == 0) begin
                  check(i, 0, "unexpected_we", {wradr[i], wrdat[i]}, 0);
               end else begin
                  w = wr_q[i].pop_front();
                  check(i, prev_ack[i] && !prev_err[i] && wradr[i] == w.adr && wrdat[i] == w.dat,
                        "cache_write", {wradr[i], wrdat[i]}, {w.adr, w.dat});
               end
            end
            if (err[i]) begin
               check(i, exp_err[i] > 0 && prev_err[i], "err_pulse", {prev_err[i]}, exp_err[i]);
               if (exp_err[i] > 0) exp_err[i]--;
            end
            prev_ack[i] = pres;
            prev_err[i] = pres && berr[i];
            prev_end[i] = ends;
         end
      end
   end

   // Expected order: word offsets from the critical word, wrapping modulo the line size.
   task automatic start_refill(int d, logic [31:0] a, int nbus, int nwr, int nerr);
      logic [31:0] lb, base, off, ea;
      lb   = 32'(line_bytes(d));
      base = a & ~(lb - 32'd1);
      off  = a & (lb - 32'd1) & ~32'h3;
      for (int i = 0; i < nbus; i++) begin
         ea = base + ((off + 32'(4 * i)) % lb);
         bus_q[d].push_back('{adr: ea, last: (i == line_bytes(d) / 4 - 1)});
         if (i < nwr) wr_q[d].push_back('{adr: ea, dat: mem_f(ea)});
      end
      exp_err[d] += nerr;
      check(d, !cyc[d], "idle_before_req", {cyc[d]}, 0);
      radr[d] = a;
      req[d]  = 1'b1;
      @(negedge clk);
      check(d, cyc[d] && stb[d], "req_to_cyc_latency", {cyc[d], stb[d]}, 2'b11);
   endtask

   task automatic wait_done(int d);
      bit done = 0;
      for (int n = 0; n < 300 && !done; n++) begin
         @(negedge clk);
         done = !cyc[d] && bus_q[d].size() == 0 && wr_q[d].size() == 0 && exp_err[d] == 0;
      end
      check(d, done, "burst_complete", {bus_q[d].size(), wr_q[d].size()}, 0);
   endtask

   task automatic wait_acks(int d, int target);
      bit hit = 0;
      for (int n = 0; n < 200 && !hit; n++) begin
         @(negedge clk);
         hit = (n_ack[d] >= target);
      end
      check(d, hit, "ack_count_reached", n_ack[d], target);
   endtask

   task automatic hold_idle(int d, int cycles, string name);
      bit ok = 1;
      repeat (cycles) begin
         @(negedge clk);
         ok &= !cyc[d] && !stb[d] && !we[d];
      end
      check(d, ok, name, {ok}, 1);
   endtask

   task automatic end_refill(int d);
      wait_done(d);
      req[d] = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic full_refill(int d, logic [31:0] a);
      start_refill(d, a, line_bytes(d) / 4, line_bytes(d) / 4, 0);
      end_refill(d);
   endtask

   task automatic check_reset_state(int d);
      check(d, !cyc[d] && !stb[d] && !we[d] && !err[d], "reset_ctl",
            {cyc[d], stb[d], we[d], err[d]}, 0);
      check(d, adr[d] == 0 && wradr[d] == 0 && wrdat[d] == 0, "reset_data",
            {adr[d], wradr[d]}, 0);
   endtask

   initial begin
      int base_n;
      int d;
      rst  = 1'b1;
      salt = $urandom;
      for (int i = 0; i < 2; i++) begin
         req[i] = 1'b0; radr[i] = '0;
         max_wait[i] = 0; err_beat[i] = 0; exp_err[i] = 0;
      end
      #23;
      check_reset_state(0);
      check_reset_state(1);
      rst = 1'b0;
      @(negedge clk);
      hold_idle(0, 3, "idle_without_req");
      hold_idle(1, 3, "idle_without_req");

      full_refill(0, 32'h0000_2000);
      full_refill(0, 32'h0000_1014);
      max_wait[1] = 3;
      full_refill(1, 32'h0000_3008);

      // Error on beat 3 with ack also high; request stays up and must not restart a burst.
      err_beat[0] = 3;
      start_refill(0, 32'h0000_4008, 3, 2, 1);
      wait_done(0);
      hold_idle(0, 10, "no_restart_while_req_high");
      req[0] = 1'b0;
      @(negedge clk);
      err_beat[0] = 0;
      @(negedge clk);
      full_refill(0, 32'h0000_4008);

      // Asynchronous reset mid-burst, off the clock edge.
      base_n = n_ack[0];
      start_refill(0, 32'h0000_5004, 8, 4, 0);
      wait_acks(0, base_n + 4);
      #2 rst = 1'b1;
      #1;
      check(0, !cyc[0] && !stb[0] && !we[0], "async_reset_drop", {cyc[0], stb[0], we[0]}, 0);
      req[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #3 rst = 1'b0;
      bus_q[0].delete();
      wr_q[0].delete();
      @(negedge clk);
      check_reset_state(0);
      hold_idle(0, 4, "idle_after_reset");
      full_refill(0, 32'h0000_600c);

      // Request withdrawn after beat 2: bus completes, cache writes stop.
      base_n = n_ack[0];
      start_refill(0, 32'h0000_7018, 8, 2, 0);
      wait_acks(0, base_n + 2);
      req[0] = 1'b0;
      wait_done(0);
      @(negedge clk);
      @(negedge clk);

      repeat (12) begin
         d = int'($urandom_range(1, 0));
         max_wait[d] = int'($urandom_range(3, 0));
         full_refill(d, $urandom);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

endmodule
